// File: rtl/primegen.sv
// primegen: ascending prime generator (1,2,3,5,...) by trial division behind a go/ready handshake; clk, rst (async active-low), go in; ready, sticky error, 16-bit res out
module primegen (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic        ready,
  output logic        error,
  output logic [15:0] res
);
  typedef enum logic [2:0] {IDLE, NEXT, TEST, DIV, CHECK, DONE, ERR} state_t;
  state_t state, state_nx;
  logic go_q, error_nx;
  logic [15:0] res_nx, dvd, dvd_nx;
  logic [16:0] c, c_nx, sq, sq_nx;
  logic [8:0] d, d_nx, rem, rem_nx;
  logic [3:0] cnt, cnt_nx;
  logic [9:0] shift, diff;
  assign ready = state == IDLE;
  assign shift = {rem, dvd[15]};
  assign diff = shift - {1'b0, d};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      go_q  <= 1'b0;
      error <= 1'b0;
      res   <= 16'd1;
      c     <= '0;
      d     <= '0;
      sq    <= '0;
      dvd   <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      go_q  <= go;
      error <= error_nx;
      res   <= res_nx;
      c     <= c_nx;
      d     <= d_nx;
      sq    <= sq_nx;
      dvd   <= dvd_nx;
      rem   <= rem_nx;
      cnt   <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    error_nx = error;
    res_nx   = res;
    c_nx     = c;
    d_nx     = d;
    sq_nx    = sq;
    dvd_nx   = dvd;
    rem_nx   = rem;
    cnt_nx   = cnt;
    case (state)
      IDLE: state_nx = go && !go_q && !error ? NEXT : IDLE;
      NEXT: begin
        c_nx     = res == 16'd1 ? 17'd2 : res == 16'd2 ? 17'd3 : {1'b0, res} + 17'd2;
        d_nx     = 9'd3;
        sq_nx    = 17'd9;
        state_nx = res <= 16'd2 || 17'd9 > c_nx ? DONE : TEST;
      end
      TEST: begin
        dvd_nx   = c[15:0];
        rem_nx   = '0;
        cnt_nx   = '0;
        state_nx = DIV;
      end
      DIV: begin
        rem_nx   = diff[9] ? shift[8:0] : diff[8:0];
        dvd_nx   = {dvd[14:0], 1'b0};
        cnt_nx   = cnt + 4'd1;
        state_nx = cnt == 4'd15 ? CHECK : DIV;
      end
      CHECK:
        if (rem == '0) begin
          c_nx     = c + 17'd2;
          d_nx     = 9'd3;
          sq_nx    = 17'd9;
          state_nx = c_nx[16] ? ERR : TEST;
        end else begin
          sq_nx    = sq + {6'd0, d, 2'd0} + 17'd4;
          d_nx     = d + 9'd2;
          state_nx = sq_nx > c ? DONE : TEST;
        end
      DONE: begin
        res_nx   = c[15:0];
        state_nx = IDLE;
      end
      ERR: begin
        error_nx = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_primegen.sv
// tb_primegen: directed self-checking bench for primegen
module tb_primegen;
  logic clk = 1'b0, rst = 1'b0, go = 1'b0, ready, error;
  logic [15:0] res;
  int n_checks = 0, n_fail = 0, cyc = 0;
  bit to, rdy_start;
  primegen dut (.clk(clk), .rst(rst), .go(go), .ready(ready), .error(error), .res(res));
  always #5 clk = ~clk;
  task automatic do_reset;
    rst = 1'b0;
    go = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic step;
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1;
    rdy_start = ready;
    go = 1'b0;
    cyc = 0;
    while (!ready && cyc < 100000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    to = !ready;
  endtask
  task automatic test_reset;
    do_reset();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_checks++; if (res !== 16'd1) begin n_fail++; $display("FAIL reset_res: got %0d expected 1", res); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
  endtask
  task automatic test_sequence;
    int exp_seq[12] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++; if (to) begin n_fail++; $display("FAIL seq_timeout[%0d]: ready low after %0d cycles", i, cyc); end
      n_checks++; if (res !== exp_seq[i][15:0]) begin n_fail++; $display("FAIL seq_res[%0d]: got %0d expected %0d", i, res, exp_seq[i]); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL seq_error[%0d]: got %b expected 0", i, error); end
      if (i < 2) begin
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL seq_latency[%0d]: got %0d expected 2", i, cyc); end
      end
    end
  endtask
  task automatic test_latency;
    do_reset();
    repeat (4) step();
    step();
    n_checks++; if (rdy_start !== 1'b0) begin n_fail++; $display("FAIL lat_ready_low: got %b expected 0", rdy_start); end
    n_checks++; if (cyc !== 38) begin n_fail++; $display("FAIL lat_cycles: got %0d expected 38", cyc); end
    n_checks++; if (res !== 16'd11) begin n_fail++; $display("FAIL lat_res: got %0d expected 11", res); end
  endtask
  task automatic test_held_go;
    int rises = 0;
    logic prev;
    do_reset();
    step();
    @(negedge clk);
    go = 1'b1;
    prev = ready;
    repeat (5000) begin
      @(negedge clk);
      if (ready && !prev) rises++;
      prev = ready;
    end
    n_checks++; if (rises !== 1) begin n_fail++; $display("FAIL held_rises: got %0d expected 1", rises); end
    n_checks++; if (res !== 16'd3) begin n_fail++; $display("FAIL held_res: got %0d expected 3", res); end
    go = 1'b0;
    step();
    n_checks++; if (res !== 16'd5) begin n_fail++; $display("FAIL held_next_res: got %0d expected 5", res); end
  endtask
  task automatic test_reset_busy;
    do_reset();
    repeat (11) step();
    n_checks++; if (res !== 16'd31) begin n_fail++; $display("FAIL busy_pre_res: got %0d expected 31", res); end
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b expected 0", ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL busy_rst_ready: got %b expected 1", ready); end
    n_checks++; if (res !== 16'd1) begin n_fail++; $display("FAIL busy_rst_res: got %0d expected 1", res); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL busy_rst_error: got %b expected 0", error); end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_checks++; if (res !== 16'd2) begin n_fail++; $display("FAIL busy_after_res: got %0d expected 2", res); end
  endtask
  task automatic test_overflow;
    do_reset();
    @(negedge clk);
    force dut.res = 16'd65521;
    @(negedge clk);
    @(negedge clk);
    release dut.res;
    @(negedge clk);
    step();
    n_checks++; if (to) begin n_fail++; $display("FAIL ovf_timeout: ready low after %0d cycles", cyc); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_error: got %b expected 1", error); end
    n_checks++; if (res !== 16'd65521) begin n_fail++; $display("FAIL ovf_res: got %0d expected 65521", res); end
    step();
    n_checks++; if (rdy_start !== 1'b1) begin n_fail++; $display("FAIL ovf_ignored_ready: got %b expected 1", rdy_start); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_error: got %b expected 1", error); end
    n_checks++; if (res !== 16'd65521) begin n_fail++; $display("FAIL ovf_hold_res: got %0d expected 65521", res); end
  endtask
  initial begin
    test_reset();
    test_sequence();
    test_latency();
    test_held_go();
    test_reset_busy();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/primegen.md
# primegen

Sequential prime-number generator producing the ascending sequence 1, 2, 3, 5, 7, 11, … one value per request. Each request is a `go` strobe. Candidates are tested by trial division using an iterative divider. The block sits as a standalone compute engine behind a simple go/ready handshake and flags `error` when the next prime does not fit in 16 bits.

## Interface
- No parameters; result width is fixed at 16 bits.
- `clk` input 1 — single clock; all state updates on its rising edge.
- `rst` input 1 — reset, asynchronous, active-low.
- `go` input 1 — request the next prime. Acted on at the rising edge of `go` while idle.
- `ready` output 1 — high when `res` holds a valid result and the block is idle.
- `error` output 1 — sticky; high once the sequence has overflowed 16 bits.
- `res` output 16 — current sequence value, unsigned.

## Operation
- Reset values: `ready`=1, `res`=1, `error`=0, state IDLE, internal registered `go` = 0.
- Go detection:
  - Detection uses a registered copy of `go`. A start occurs when `go`=1 and last-cycle `go`=0, state is IDLE, and `error`=0.
  - `go` while busy is ignored. `go` while `error`=1 is ignored (`ready` stays 1).
- States:
  - IDLE: `ready`=1. On a start, go to NEXT.
  - NEXT: choose the candidate `c`.
    - `res`=1 gives c=2; `res`=2 gives c=3. Both go straight to DONE.
    - Otherwise c=`res`+2, computed in 17 bits. Set d=3 and sq=9, then go to TEST.
  - TEST:
    - If sq > c, c is prime; go to DONE.
    - Otherwise load the divider with c/d and go to DIV.
  - DIV: 16-cycle restoring divider, one quotient bit per cycle. It produces only the remainder r = c mod d. Then go to CHECK.
  - CHECK:
    - If r=0, c is composite: set c=c+2, d=3, sq=9.
      - If c > 65535 (carry out of 16 bits), go to ERR.
      - Otherwise go to TEST.
    - If r≠0: set sq = sq + 4·d + 4, d = d+2, then go to TEST.
  - DONE: `res`←c, `ready`←1, return to IDLE.
  - ERR: `error`←1, `ready`←1, `res` unchanged (holds 65521). Return to IDLE.
- Width rules:
  - c and sq are 17 bits. d is 9 bits; d never exceeds 257 because sq > c stops the loop.
  - The sq update is exact; no multiplier is required.
- Even candidates above 2 are never generated. d takes odd values only.

## Timing
- `ready` falls in the cycle after the clock edge that detects the start (state NEXT or later).
- `res` changes on the same edge on which `ready` rises. The value is stable for the whole time `ready`=1 and holds its previous value while busy.
- Latency:
  - 1→2 and 2→3: 2 cycles from the start edge to `ready` high.
  - Other steps: 1 + Σ over trial divisions of 18 cycles (TEST + 16 DIV + CHECK), plus 1 cycle for DONE.
  - Every step is bounded by 100,000 cycles.
- Reset asserted mid-computation immediately forces the reset values, without waiting for a clock. Release is synchronous to the next clock edge.
- A `go` held high across completion does not start a second step; it must return low first.
- After `error` is set, only reset clears it.

## Test plan
- Reset low then released, checked before any `go` → `ready`=1, `res`=1, `error`=0.
- Twelve one-cycle `go` pulses, each waiting for `ready` to rise → `res` sequence is 2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37. `error` stays 0 and `res` never contains X at `ready` rise.
- Single `go` from `res`=7 → `ready` low one cycle after the edge. It returns with `res`=11 after exactly 1+2·18+1 cycles: the candidate 9 fails on d=3 (one division), and 11 passes d=3 (one division) before 25 > 11.
- `go` held high for 5,000 cycles starting at `res`=2 → exactly one step, giving `res`=3. A second pulse then gives 5.
- Pulse `go` repeatedly until `res`=65521, then pulse again → `ready` rises with `error`=1 and `res`=65521. A further `go` leaves `ready`=1, `error`=1, `res`=65521.
- Assert reset while busy computing from 31 → outputs immediately show `ready`=1, `res`=1, `error`=0. The next `go` yields 2.
